// File: rtl/traffic_pkg.sv
// Shared definitions for the farm-road detector and trafficlight controller:
// light bus layout, colour encodings and the detector FSM states.
package traffic_pkg;

  localparam int HWY_R  = 5;
  localparam int HWY_Y  = 4;
  localparam int HWY_G  = 3;
  localparam int FARM_R = 2;
  localparam int FARM_Y = 1;
  localparam int FARM_G = 0;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Controller's reset pattern: highway green, farm red.
  localparam logic [5:0] LIGHT_RESET = 6'b001100;

  typedef enum logic [1:0] {IDLE, REQ, SERVE, CLEAR} det_state_t;

  // Legal means each road shows exactly one lamp and at least one road is red.
  function automatic logic light_legal(input logic [5:0] l);
    logic [2:0] hwy;
    logic [2:0] farm;
    hwy  = {l[HWY_R], l[HWY_Y], l[HWY_G]};
    farm = {l[FARM_R], l[FARM_Y], l[FARM_G]};
    return $onehot(hwy) && $onehot(farm) && (l[HWY_R] || l[FARM_R]);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer: the output only
// flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic       s1_q, s2_q;
  logic       db_q;
  logic [3:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; the s1_q -> s2_q chain depends on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
        db_q  <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/car_detector.sv
// Farm-road request latch: debounced sensor in, registered car request out,
// released only once the controller has shown farm green.
module car_detector
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_raw,
  input  logic [5:0] light,
  output logic       car,
  output logic       served,
  output logic [7:0] wait_cnt,
  output logic       stuck_err,
  output logic       light_err
);

  logic       sensor_db;
  logic       farm_green, farm_red;
  det_state_t state_q, state_d;
  logic       car_q, car_d;
  logic       served_q, served_d;
  logic [7:0] wait_q, wait_d;
  logic       stuck_q, stuck_d;
  logic       lerr_q, lerr_d;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (sensor_raw),
    .dout (sensor_db)
  );

  assign farm_green = (light[FARM_R:FARM_G] == GRN);
  assign farm_red   = (light[FARM_R:FARM_G] == RED);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    served_d = 1'b0;
    stuck_d  = stuck_q;
    lerr_d   = lerr_q | ~light_legal(light);
    case (state_q)
      IDLE: begin
        if (sensor_db) begin
          if (farm_green) begin
            state_d = SERVE;
          end else begin
            state_d = REQ;
            wait_d  = '0;
          end
        end
      end
      REQ: begin
        wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        if (wait_d >= 8'(TIMEOUT_CYCLES)) stuck_d = 1'b1;
        if (farm_green) state_d = SERVE;
      end
      SERVE: begin
        if (!farm_green) begin
          state_d  = CLEAR;
          served_d = 1'b1;
        end
      end
      CLEAR: begin
        if (!sensor_db) begin
          state_d = IDLE;
        end else if (farm_red) begin
          state_d = REQ;
          wait_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // During SERVE the request tracks the sensor so green can be extended.
    car_d = (state_d == REQ) || ((state_d == SERVE) && sensor_db);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      car_q    <= 1'b0;
      served_q <= 1'b0;
      wait_q   <= '0;
      stuck_q  <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      car_q    <= car_d;
      served_q <= served_d;
      wait_q   <= wait_d;
      stuck_q  <= stuck_d;
      lerr_q   <= lerr_d;
    end
  end

  assign car       = car_q;
  assign served    = served_q;
  assign wait_cnt  = wait_q;
  assign stuck_err = stuck_q;
  assign light_err = lerr_q;

endmodule

// File: tb/tb_car_detector.sv
// Scoreboard bench for car_detector: the stimulus queues the expected outputs
// for each clock edge, a monitor pops and compares them just after the edge.
module tb_car_detector;
  import traffic_pkg::*;

  localparam logic [5:0] L0  = LIGHT_RESET;   // highway green, farm red
  localparam logic [5:0] LFG = {RED, GRN};    // farm green
  localparam logic [5:0] LFY = {RED, YEL};    // farm yellow
  localparam logic       X   = 1'bx;          // field not checked

  typedef struct {
    string      nm;
    logic       car;
    logic       served;
    logic [7:0] wc;
    logic       stuck;
    logic       lerr;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_raw = 1'b0;
  logic [5:0] light = L0;
  logic       car, served, stuck_err, light_err;
  logic [7:0] wait_cnt;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event async_ev;

  car_detector #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .light      (light),
    .car        (car),
    .served     (served),
    .wait_cnt   (wait_cnt),
    .stuck_err  (stuck_err),
    .light_err  (light_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(string nm, logic c, logic s, logic [7:0] w,
                              logic k, logic l, logic [1:0] st);
    exp_t x;
    x.nm = nm; x.car = c; x.served = s; x.wc = w;
    x.stuck = k; x.lerr = l; x.st = st;
    return x;
  endfunction

  task automatic check(string nm, string fld, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h expected %0h (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge and queue what the next rising edge must produce.
  task automatic step(input logic raw, input logic [5:0] lt, input exp_t x);
    @(negedge clk);
    sensor_raw = raw;
    light      = lt;
    q.push_back(x);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        if (!$isunknown(x.car))    check(x.nm, "car",       8'(car),         8'(x.car));
        if (!$isunknown(x.served)) check(x.nm, "served",    8'(served),      8'(x.served));
        if (!$isunknown(x.wc))     check(x.nm, "wait_cnt",  wait_cnt,        x.wc);
        if (!$isunknown(x.stuck))  check(x.nm, "stuck_err", 8'(stuck_err),   8'(x.stuck));
        if (!$isunknown(x.lerr))   check(x.nm, "light_err", 8'(light_err),   8'(x.lerr));
        if (!$isunknown(x.st))     check(x.nm, "state",     8'(dut.state_q), 8'(x.st));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] w;

    // Reset state while rst is held.
    repeat (2) step(1'b0, L0, mk("reset", 0, 0, 8'd0, 0, 0, IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Three-cycle glitch must never reach the request.
    repeat (3) step(1'b1, L0, mk("glitch_hi", 0, 0, 8'd0, 0, 0, IDLE));
    repeat (8) step(1'b0, L0, mk("glitch_lo", 0, 0, 8'd0, 0, 0, IDLE));

    // Clean request: car rises after edge 7, wait_cnt 0,1,2,...
    for (int n = 1; n <= 10; n++)
      step(1'b1, L0, mk("clean_req", logic'(n >= 7), 0,
                        (n >= 7) ? 8'(n - 7) : 8'd0, 0, 0, (n >= 7) ? REQ : IDLE));
    // Vehicle leaves (debounced low after edge 16); the request stays latched.
    for (int n = 11; n <= 20; n++)
      step(1'b0, L0, mk("latched", 1, 0, 8'(n - 7), 0, 0, REQ));
    // Farm green: the REQ cycle counts once more (14), then car follows sensor_db=0.
    for (int n = 21; n <= 25; n++)
      step(1'b0, LFG, mk("serve", 0, 0, 8'd14, 0, 0, SERVE));
    step(1'b0, LFY, mk("served_pulse", 0, 1, 8'd14, 0, 0, CLEAR));
    step(1'b0, LFY, mk("back_idle", 0, 0, 8'd14, 0, 0, IDLE));
    repeat (3) step(1'b0, L0, mk("idle_hold", 0, 0, 8'd14, 0, 0, IDLE));

    // Timeout: stuck_err exactly when wait_cnt reaches 20, saturation at 255.
    for (int n = 1; n <= 270; n++) begin
      if (n < 7)             w = 8'd14;
      else if (n - 7 > 255)  w = 8'd255;
      else                   w = 8'(n - 7);
      step(1'b1, L0, mk("timeout", logic'(n >= 7), 0, w, logic'(n >= 27), 0,
                        (n >= 7) ? REQ : IDLE));
    end

    // Illegal pattern (both greens) is also farm green, so the FSM serves.
    step(1'b1, 6'b001001, mk("illegal", 1, 0, 8'd255, 1, 1, SERVE));
    step(1'b1, L0, mk("after_illegal", 0, 1, 8'd255, 1, 1, CLEAR));
    step(1'b1, L0, mk("stranded", 1, 0, 8'd0, 1, 1, REQ));
    step(1'b1, L0, mk("req_again", 1, 0, 8'd1, 1, 1, REQ));

    // Asynchronous reset mid-request, checked before any clock edge.
    @(negedge clk);
    #2;
    q.push_back(mk("async_rst", 0, 0, 8'd0, 0, 0, IDLE));
    rst = 1'b1;
    -> async_ev;
    repeat (2) step(1'b0, L0, mk("in_rst", 0, 0, 8'd0, 0, 0, IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Neither road red is illegal; the flag is sticky afterwards.
    step(1'b0, L0, mk("post_rst", 0, 0, 8'd0, 0, 0, IDLE));
    step(1'b0, 6'b010010, mk("no_red", 0, 0, 8'd0, 0, 1, IDLE));
    step(1'b0, L0, mk("lerr_sticky", 0, 0, 8'd0, 0, 1, IDLE));

    @(negedge clk);
    check("drain", "queue", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
